// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - Word-addressed 16-bit data memory with combinational load and writeback bundle
// Stores commit on the rising edge; loads and the writeback bundle are purely combinational.
module memory_unit #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        isld,
  input  logic        isst,
  input  logic [15:0] instr,
  input  logic [15:0] op2,
  input  logic [15:0] aluresult,
  output logic [15:0] ldresult,
  output logic [19:0] rdvalmem
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] w_addr;
  logic [15:0]   w_rd_word;
  logic          w_unused_bits;

  // Upper address bits are dropped, so accesses wrap modulo DEPTH.
  assign w_addr        = aluresult[AW-1:0];
  assign w_unused_bits = ^{instr[15:8], instr[4:0], aluresult};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (isst) begin
      r_mem[w_addr] <= op2;
    end
  end

  assign w_rd_word = r_mem[w_addr];
  assign ldresult  = isld ? w_rd_word : 16'h0000;

  // Stores do not write a register, so valid drops whenever isst is high.
  assign rdvalmem  = {~isst, instr[7:5], isld ? ldresult : aluresult};

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - Self-checking bench for memory_unit: vector table, scoreboard, corner sequences
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        isld;
  logic        isst;
  logic [15:0] instr;
  logic [15:0] op2;
  logic [15:0] aluresult;
  logic [15:0] ldresult;
  logic [19:0] rdvalmem;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model [256];

  typedef struct {
    logic        st_en;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        ld;
    logic        st;
    logic [15:0] addr;
    logic [15:0] ins;
    logic [15:0] exp_ld;
    logic [19:0] exp_rv;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] ld;
    logic [19:0] rv;
  } exp_t;

  exp_t sb[$];

  memory_unit #(.DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .isld      (isld),
    .isst      (isst),
    .instr     (instr),
    .op2       (op2),
    .aluresult (aluresult),
    .ldresult  (ldresult),
    .rdvalmem  (rdvalmem)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%05h req=%05h", name, act, req);
    end
  endtask

  task automatic push_exp(input string name, input logic [15:0] ld, input logic [19:0] rv);
    exp_t e;
    e.name = name;
    e.ld   = ld;
    e.rv   = rv;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: act=0 req=1");
    end else begin
      n_tests--;
      e = sb.pop_front();
      chk({e.name, "_ld"}, {4'h0, ldresult}, {4'h0, e.ld});
      chk({e.name, "_rv"}, rdvalmem, e.rv);
    end
  endtask

  // Entered and left at posedge+1 so every input change sits well away from the edge.
  task automatic do_store(input logic [15:0] a, input logic [15:0] d);
    isld      = 1'b0;
    isst      = 1'b1;
    aluresult = a;
    op2       = d;
    @(posedge clk);
    #1;
    isst = 1'b0;
    model[a[7:0]] = d;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [15:0] a, input logic [15:0] ins);
    isld      = ld;
    isst      = st;
    aluresult = a;
    instr     = ins;
    #1;
  endtask

  function automatic logic [19:0] model_rv(input logic ld, input logic st,
                                           input logic [15:0] a, input logic [15:0] ins);
    logic [15:0] v;
    v = ld ? model[a[7:0]] : a;
    return {~st, ins[7:5], v};
  endfunction

  vec_t vecs[10];

  initial begin
    logic [15:0] ra, rd, ri;
    logic        rl;

    vecs[0] = '{1'b1, 16'h000A, 16'hAAAA, 1'b1, 1'b0, 16'h000A, 16'h00E0, 16'hAAAA, 20'hFAAAA};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 16'h0000, 20'hD0010};
    vecs[2] = '{1'b1, 16'h0105, 16'h1234, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 20'h81234};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0105, 16'h0000, 16'h1234, 20'h81234};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0020, 16'h00FF, 16'h0000, 20'h70020};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFF0A, 16'h0040, 16'hAAAA, 20'hAAAAA};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0033, 16'h0020, 16'h0000, 20'h90000};
    vecs[7] = '{1'b1, 16'h00FF, 16'hBEEF, 1'b1, 1'b0, 16'h00FF, 16'h00A0, 16'hBEEF, 20'hDBEEF};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00FE, 16'h0000, 16'h0000, 20'h80000};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 20'hFFFFF};

    for (int i = 0; i < 256; i++) model[i] = 16'h0000;

    rst_n = 1'b0; isld = 1'b0; isst = 1'b0; instr = 16'h0000; op2 = 16'h0000; aluresult = 16'h0000;

    // Reset state, plus a store attempted across an edge while reset is held.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0002, 16'h0701);
    push_exp("reset_load", 16'h0000, 20'h80000);
    pop_cmp();
    isld = 1'b0; isst = 1'b1; aluresult = 16'h0009; op2 = 16'hDEAD;
    @(posedge clk); #1;
    isst = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0009, 16'h0000);
    push_exp("store_blocked_in_reset", 16'h0000, 20'h80000);
    pop_cmp();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].st_en) do_store(vecs[i].st_addr, vecs[i].st_data);
      drive(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].ins);
      push_exp($sformatf("vec%0d", i), vecs[i].exp_ld, vecs[i].exp_rv);
      pop_cmp();
      isst = 1'b0;
      @(posedge clk); #1;
    end

    // Simultaneous load and store: old word before the edge, new word after.
    do_store(16'h0007, 16'h0001);
    isld = 1'b1; isst = 1'b1; aluresult = 16'h0007; op2 = 16'h0002; instr = 16'h0000;
    #1;
    push_exp("ldst_before", 16'h0001, 20'h00001);
    pop_cmp();
    @(posedge clk); #1;
    push_exp("ldst_after", 16'h0002, 20'h00002);
    pop_cmp();
    isst = 1'b0; isld = 1'b0;
    model[7] = 16'h0002;

    // Asynchronous clear between edges wipes stored data.
    do_store(16'h0003, 16'h5555);
    drive(1'b1, 1'b0, 16'h0003, 16'h0000);
    push_exp("pre_reset_word", 16'h5555, 20'h85555);
    pop_cmp();
    #2 rst_n = 1'b0;
    #1;
    push_exp("during_reset", 16'h0000, 20'h80000);
    pop_cmp();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0003, 16'h0000);
    push_exp("post_reset_word", 16'h0000, 20'h80000);
    pop_cmp();
    drive(1'b1, 1'b0, 16'h000A, 16'h0000);
    push_exp("post_reset_other", 16'h0000, 20'h80000);
    pop_cmp();

    // Reset released mid-cycle with a store pending: first store lands at the following edge.
    isst = 1'b1; isld = 1'b1; aluresult = 16'h0011; op2 = 16'h7E7E; instr = 16'h0000;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    push_exp("release_before_edge", 16'h0000, 20'h00000);
    pop_cmp();
    @(posedge clk); #1;
    push_exp("release_after_edge", 16'h7E7E, 20'h07E7E);
    pop_cmp();
    isst = 1'b0; isld = 1'b0;
    model[8'h11] = 16'h7E7E;

    // Random stores followed by model-checked loads across the whole space.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rd = 16'($urandom);
      do_store(ra, rd);
    end
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      ri = 16'($urandom);
      rl = 1'($urandom_range(0, 1));
      if (i % 3 == 0) ra = {8'($urandom), ra[7:0] ^ 8'h00};
      drive(rl, 1'b0, ra, ri);
      push_exp($sformatf("rand%0d", i), rl ? model[ra[7:0]] : 16'h0000, model_rv(rl, 1'b0, ra, ri));
      pop_cmp();
    end
    // Sweep that no other word was disturbed by any store so far.
    for (int a = 0; a < 256; a += 17) begin
      drive(1'b1, 1'b0, 16'(a), 16'h0000);
      push_exp($sformatf("sweep%0d", a), model[a], model_rv(1'b1, 1'b0, 16'(a), 16'h0000));
      pop_cmp();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of 16-bit data-memory words (power of two, 2..65536).
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port isld, input, 1 bit: current instruction is a load.
REQ-006 Port isst, input, 1 bit: current instruction is a store.
REQ-007 Port instr, input, 16 bits: current instruction word; instr[7:5] is the destination register index rd.
REQ-008 Port op2, input, 16 bits: store data.
REQ-009 Port aluresult, input, 16 bits: effective memory address for load/store; result value for non-memory instructions.
REQ-010 Port ldresult, output, 16 bits: data read by a load.
REQ-011 Port rdvalmem, output, 20 bits: writeback bundle {valid, rd[2:0], value[15:0]}.

Function
REQ-012 Memory SHALL be DEPTH x 16-bit words, word-addressed; address = aluresult[log2(DEPTH)-1:0]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH.
REQ-013 Store: when isst=1 at a rising clk edge with rst_n=1, mem[addr] SHALL be written with op2; no write otherwise.
REQ-014 Load read SHALL be combinational: ldresult = mem[addr] while isld=1; ldresult = 16'h0000 while isld=0.
REQ-015 rdvalmem[15:0] SHALL be ldresult when isld=1, else aluresult.
REQ-016 rdvalmem[18:16] SHALL equal instr[7:5] at all times.
REQ-017 rdvalmem[19] (valid) SHALL be 1 when isst=0, and 0 when isst=1 (stores do not write a register).
REQ-018 All outputs SHALL be combinational functions of inputs and memory contents; zero cycles latency from input change.
REQ-019 Written data SHALL be visible to a load of the same address immediately after the writing clock edge.
REQ-020 Simultaneous isld=1 and isst=1: store SHALL occur at the edge; before the edge ldresult SHALL show the old word, after the edge the new word; rdvalmem[19] SHALL be 0.
REQ-021 Store to an address SHALL NOT modify any other word.

Reset
REQ-022 While rst_n=0, every memory word SHALL be cleared to 16'h0000 asynchronously and stores SHALL be blocked.
REQ-023 Outputs SHALL NOT be registered; during reset they SHALL follow REQ-014..REQ-017 using the cleared memory (ldresult reads 0).
REQ-024 Reset deasserted between edges mid-operation SHALL take effect for stores from the next rising edge only.

Verification
REQ-025 After reset, isld=1, aluresult=16'h0002, instr=16'h0701 -> ldresult=16'h0000, rdvalmem=20'h80000.
REQ-026 isst=1, aluresult=16'h000A, op2=16'hAAAA, one clk edge; then isst=0, isld=1, aluresult=16'h000A, instr=16'h00E0 -> ldresult=16'hAAAA, rdvalmem=20'hFAAAA.
REQ-027 isld=0, isst=0, aluresult=16'h0010, instr=16'hA5A5 -> ldresult=16'h0000, rdvalmem=20'hD0010.
REQ-028 Store 16'h1234 at aluresult=16'h0105 (DEPTH=256); load aluresult=16'h0005 -> ldresult=16'h1234 (wrap-around).
REQ-029 Store 16'h5555 to address 3, assert rst_n=0 between edges, release; load address 3 -> ldresult=16'h0000.
REQ-030 isld=1, isst=1, address 7 holding 16'h0001, op2=16'h0002 -> ldresult=16'h0001 before edge, 16'h0002 after edge, rdvalmem[19]=0.
